if_id_buffer: RTL and testbench

Instruction-fetch/decode decoupling stage that sits directly downstream of the fetch unit. Each cycle it captures the fetched instruction word with its PC and PC+4, holds up to DEPTH entries in a small in-order queue, and presents the oldest entry to the decode/control stage under a valid/ready handshake. A redirect (taken beq, jal, jr) flushes every held entry, so wrong-path instructions never reach decode.

---
 rtl/if_id_buffer_pkg.sv | 12 +
 rtl/if_id_fifo_ptr.sv | 53 +++++
 rtl/if_id_buffer.sv | 59 +++++
 tb/tb_if_id_buffer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/if_id_buffer_pkg.sv
// if_id_buffer_pkg: shared CPU constants and the IF/ID entry bundle
package if_id_buffer_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;
    localparam logic [XLEN-1:0] RESET_PC4 = 32'h0000_3004;
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } entry_t;
endpackage

// File: rtl/if_id_fifo_ptr.sv
// if_id_fifo_ptr: pointers, occupancy and push/pop/flush qualification for the IF/ID queue
module if_id_fifo_ptr
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid_i,
    input  logic          out_ready_i,
    input  logic          flush_i,
    output logic          push_o,
    output logic          pop_o,
    output logic          in_ready_o,
    output logic          out_valid_o,
    output logic          empty_o,
    output logic [AW-1:0] wr_ptr_o,
    output logic [AW-1:0] rd_ptr_o,
    output logic [AW:0]   count_o
);
    localparam int CW = AW + 1;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic full;
    assign full = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    // in_ready sees only registered state, so a pop never frees a slot in the same cycle
    assign in_ready_o = !full && reset;
    assign out_valid_o = !empty_o;
    assign push_o = in_valid_i && in_ready_o && !flush_i;
    assign pop_o = out_valid_o && out_ready_i && !flush_i;
    always_comb begin
        wr_d = flush_i ? '0 : push_o ? wr_q + AW'(1) : wr_q;
        rd_d = flush_i ? '0 : pop_o ? rd_q + AW'(1) : rd_q;
        cnt_d = flush_i ? '0 : (push_o && !pop_o) ? cnt_q + CW'(1) :
                (pop_o && !push_o) ? cnt_q - CW'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    assign wr_ptr_o = wr_q;
    assign rd_ptr_o = rd_q;
    assign count_o = cnt_q;
endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: in-order fetch/decode decoupling queue, flushed on redirect
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W = XLEN,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_instr,
    input  logic [W-1:0] in_pc,
    input  logic [W-1:0] in_pc_plus4,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_instr,
    output logic [W-1:0] out_pc,
    output logic [W-1:0] out_pc_plus4,
    output logic [AW:0]  count
);
    localparam int CW = AW + 1;
    logic push, pop, empty, load_in;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    entry_t mem [DEPTH];
    entry_t beat, head_q, head_d;
    if_id_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk(clk),
        .reset(reset),
        .in_valid_i(in_valid),
        .out_ready_i(out_ready),
        .flush_i(flush),
        .push_o(push),
        .pop_o(pop),
        .in_ready_o(in_ready),
        .out_valid_o(out_valid),
        .empty_o(empty),
        .wr_ptr_o(wr_ptr),
        .rd_ptr_o(rd_ptr),
        .count_o(count)
    );
    assign beat = '{instr: in_instr, pc: in_pc, pc_plus4: in_pc_plus4};
    assign rd_nxt = rd_ptr + AW'(1);
    // the incoming beat becomes head when the queue is, or is about to be, empty
    assign load_in = push && (empty || (pop && count == CW'(1)));
    assign head_d = load_in ? beat : (pop && count != CW'(1)) ? mem[rd_nxt] : head_q;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= beat;
    end
    always_ff @(posedge clk) begin
        if (!reset) head_q <= '{NOP_INSTR, RESET_PC, RESET_PC4};
        else head_q <= head_d;
    end
    assign out_instr = out_valid ? head_q.instr : NOP_INSTR;
    assign out_pc = head_q.pc;
    assign out_pc_plus4 = head_q.pc_plus4;
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed table-driven bench for the IF/ID decoupling queue
module tb_if_id_buffer;
    logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0, in_pc_plus4 = '0;
    logic in_ready, out_valid;
    logic [31:0] out_instr, out_pc, out_pc_plus4;
    logic [1:0] count;
    int checks = 0, errors = 0;

    typedef struct {
        logic v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic fl;
        logic rdy;
        logic ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [1:0] ec;
        logic er;
    } vec_t;
    vec_t tbl[21];

    if_id_buffer #(.DEPTH(2), .W(32)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr(in_instr),
        .in_pc(in_pc),
        .in_pc_plus4(in_pc_plus4),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_pc_plus4(out_pc_plus4),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, logic [31:0] instr, logic [31:0] pc, logic fl, logic rdy,
                                logic ev, logic [31:0] ei, logic [31:0] ep, logic [1:0] ec, logic er);
        vec_t r;
        r.v = v; r.instr = instr; r.pc = pc; r.fl = fl; r.rdy = rdy;
        r.ev = ev; r.ei = ei; r.ep = ep; r.ec = ec; r.er = er;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic fl, input logic rdy);
        in_valid = v; in_instr = instr; in_pc = pc; in_pc_plus4 = pc + 32'd4;
        flush = fl; out_ready = rdy;
    endtask

    task automatic check_state(input string tag, input logic ev, input logic [31:0] ei,
                               input logic [31:0] ep, input logic [1:0] ec, input logic er);
        chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, " out_instr"}, out_instr, ei);
        chk({tag, " out_pc"}, out_pc, ep);
        chk({tag, " out_pc_plus4"}, out_pc_plus4, ep + 32'd4);
        chk({tag, " count"}, {30'd0, count}, {30'd0, ec});
        chk({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, er});
    endtask

    initial begin
        // stream two beats with decode always ready
        tbl[0]  = mk(1, 32'h2001_0005, 32'h3000, 0, 1,  1, 32'h2001_0005, 32'h3000, 1, 1);
        tbl[1]  = mk(1, 32'h2002_0003, 32'h3004, 0, 1,  1, 32'h2002_0003, 32'h3004, 1, 1);
        tbl[2]  = mk(0, 32'h0,         32'h0,    0, 1,  0, 32'h0,         32'h3004, 0, 1);
        // fill with backpressure; the third beat and the full-cycle beat are refused
        tbl[3]  = mk(1, 32'hA000_0001, 32'h3100, 0, 0,  1, 32'hA000_0001, 32'h3100, 1, 1);
        tbl[4]  = mk(1, 32'hA000_0002, 32'h3104, 0, 0,  1, 32'hA000_0001, 32'h3100, 2, 0);
        tbl[5]  = mk(1, 32'hA000_0003, 32'h3108, 0, 0,  1, 32'hA000_0001, 32'h3100, 2, 0);
        tbl[6]  = mk(1, 32'hA000_0003, 32'h3108, 0, 1,  1, 32'hA000_0002, 32'h3104, 1, 1);
        tbl[7]  = mk(0, 32'h0,         32'h0,    0, 1,  0, 32'h0,         32'h3104, 0, 1);
        // flush at count 2 with a simultaneous beat and pop
        tbl[8]  = mk(1, 32'hB000_0001, 32'h3200, 0, 0,  1, 32'hB000_0001, 32'h3200, 1, 1);
        tbl[9]  = mk(1, 32'hB000_0002, 32'h3204, 0, 0,  1, 32'hB000_0001, 32'h3200, 2, 0);
        tbl[10] = mk(1, 32'hB000_0003, 32'h3208, 1, 1,  0, 32'h0,         32'h3200, 0, 1);
        tbl[11] = mk(1, 32'hC000_0001, 32'h320C, 0, 0,  1, 32'hC000_0001, 32'h320C, 1, 1);
        tbl[12] = mk(0, 32'h0,         32'h0,    0, 1,  0, 32'h0,         32'h320C, 0, 1);
        // seven back-to-back push/pop pairs wrap both pointers
        for (int k = 0; k < 7; k++)
            tbl[13+k] = mk(1, 32'hD000_0000 + k, 32'h3000 + 4*k, 0, 1,
                           1, 32'hD000_0000 + k, 32'h3000 + 4*k, 1, 1);
        tbl[20] = mk(0, 32'h0,         32'h0,    0, 1,  0, 32'h0,         32'h3018, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 0, 32'h0, 32'h3000, 0, 0);
        reset = 1'b1;
        #1;
        chk("release in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].v, tbl[i].instr, tbl[i].pc, tbl[i].fl, tbl[i].rdy);
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ep, tbl[i].ec, tbl[i].er);
        end

        // reset in the middle of traffic, with flush also asserted
        drive(1, 32'hE000_0001, 32'h3300, 0, 0);
        @(posedge clk); #1;
        drive(1, 32'hE000_0002, 32'h3304, 0, 0);
        @(posedge clk); #1;
        check_state("pre-reset", 1, 32'hE000_0001, 32'h3300, 2, 0);
        drive(1, 32'hE000_0003, 32'h3308, 1, 1);
        reset = 1'b0;
        #1;
        chk("in_ready while reset low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check_state("mid reset", 0, 32'h0, 32'h3000, 0, 0);
        reset = 1'b1;
        drive(1, 32'hF000_0001, 32'h3400, 0, 0);
        #1;
        chk("in_ready after release", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check_state("post-reset push", 1, 32'hF000_0001, 32'h3400, 1, 1);
        drive(0, 32'h0, 32'h0, 0, 1);
        @(posedge clk); #1;
        check_state("post-reset drain", 0, 32'h0, 32'h3400, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
